// File: rtl/packet_builder.sv
// packet_builder: packs headerA, headerB and payload bytes into sop/eop bounded bus beats; PACKET_BUILDER_ERR_EN adds the proto_err output
module packet_builder #(
  parameter int WIDTH_DATA_BYTES  = 8,
  parameter int WIDTH_HDR_A_BYTES = 6,
  parameter int WIDTH_HDR_B_BYTES = 4
) (
  input  logic                            clk_host,
  input  logic                            rst_n,
  input  logic                            bus_in_valid,
  input  logic                            bus_in_sop,
  input  logic                            bus_in_eop,
  input  logic [WIDTH_DATA_BYTES-1:0]     bus_in_byteen,
  input  logic [8*WIDTH_DATA_BYTES-1:0]   bus_in_data,
  input  logic [8*WIDTH_HDR_A_BYTES-1:0]  headerA,
  input  logic [8*WIDTH_HDR_B_BYTES-1:0]  headerB,
  output logic                            bus_in_ready,
  output logic                            bus_out_valid,
  output logic                            bus_out_sop,
  output logic                            bus_out_eop,
  output logic [WIDTH_DATA_BYTES-1:0]     bus_out_byteen,
  output logic [8*WIDTH_DATA_BYTES-1:0]   bus_out_data
`ifdef PACKET_BUILDER_ERR_EN
  ,
  output logic                            proto_err
`endif
);
  localparam int W  = WIDTH_DATA_BYTES;
  localparam int H  = WIDTH_HDR_A_BYTES + WIDTH_HDR_B_BYTES;
  localparam int R  = H - W;
  localparam int CW = $clog2(2 * W + 1);
  typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_t;
  state_t state, state_n;
  logic [8*W-1:0] res, res_n, dm, d_n;
  logic [CW-1:0] r, r_n, k, s;
  logic [16*W-1:0] cat;
  logic [8*H-1:0] hdr;
  logic [W-1:0] be_n;
  logic v_n, sop_n, eop_n;
  function automatic logic [W-1:0] lanes(input logic [CW-1:0] n);
    logic [2*W-1:0] t;
    t = ((2 * W)'(1) << n) - (2 * W)'(1);
    return t[W-1:0];
  endfunction
  assign hdr = {headerB, headerA};
  always_comb begin
    k  = '0;
    dm = '0;
    for (int i = 0; i < W; i++) begin
      k = k + CW'(bus_in_byteen[i]);
      dm[8*i+:8] = bus_in_byteen[i] ? bus_in_data[8*i+:8] : 8'h00;
    end
  end
  assign s   = r + k;
  assign cat = {{(8*W){1'b0}}, res} | ({{(8*W){1'b0}}, dm} << {r, 3'b000});
`ifdef PACKET_BUILDER_ERR_EN
  logic bad, err_n;
  assign bad = bus_in_sop | (!bus_in_eop && !(&bus_in_byteen)) | ~|bus_in_byteen |
               |(bus_in_byteen & (bus_in_byteen + W'(1)));
`endif
  always_comb begin
    state_n      = state;
    res_n        = res;
    r_n          = r;
    v_n          = 1'b0;
    sop_n        = 1'b0;
    eop_n        = 1'b0;
    be_n         = '0;
    d_n          = '0;
    bus_in_ready = state == BODY;
`ifdef PACKET_BUILDER_ERR_EN
    err_n        = 1'b0;
`endif
    case (state)
      IDLE:
        if (bus_in_valid && bus_in_sop) begin
          state_n = BODY;
          res_n   = (8 * W)'(hdr >> (8 * W));
          r_n     = CW'(R);
          v_n     = 1'b1;
          sop_n   = 1'b1;
          be_n    = '1;
          d_n     = hdr[8*W-1:0];
        end
`ifdef PACKET_BUILDER_ERR_EN
        else if (bus_in_valid) begin
          bus_in_ready = 1'b1;
          err_n        = 1'b1;
        end
`endif
      BODY:
        if (bus_in_valid) begin
          v_n = 1'b1;
          d_n = cat[8*W-1:0];
`ifdef PACKET_BUILDER_ERR_EN
          err_n = bad;
`endif
          if (bus_in_eop && s <= CW'(W)) begin
            be_n    = lanes(s);
            eop_n   = 1'b1;
            res_n   = '0;
            r_n     = '0;
            state_n = IDLE;
          end else begin
            be_n    = '1;
            res_n   = cat[16*W-1:8*W];
            r_n     = s > CW'(W) ? s - CW'(W) : '0;
            state_n = bus_in_eop ? FLUSH : BODY;
          end
        end
      FLUSH: begin
        v_n     = 1'b1;
        eop_n   = 1'b1;
        be_n    = lanes(r);
        d_n     = res;
        res_n   = '0;
        r_n     = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_host)
    if (!rst_n) begin
      state          <= IDLE;
      res            <= '0;
      r              <= '0;
      bus_out_valid  <= 1'b0;
      bus_out_sop    <= 1'b0;
      bus_out_eop    <= 1'b0;
      bus_out_byteen <= '0;
      bus_out_data   <= '0;
`ifdef PACKET_BUILDER_ERR_EN
      proto_err      <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      res            <= res_n;
      r              <= r_n;
      bus_out_valid  <= v_n;
      bus_out_sop    <= sop_n;
      bus_out_eop    <= eop_n;
      bus_out_byteen <= be_n;
      bus_out_data   <= d_n;
`ifdef PACKET_BUILDER_ERR_EN
      proto_err      <= err_n;
`endif
    end
endmodule
